// File: rtl/lsu_pkg.sv
// Shared types, address map and lane helpers
// for the handshaked MMIO load-store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ACC2 = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    RG_NONE = 3'd0,
    RG_DMEM = 3'd1,
    RG_LEDR = 3'd2,
    RG_LEDG = 3'd3,
    RG_HEX  = 3'd4,
    RG_LCD  = 3'd5,
    RG_SW   = 3'd6,
    RG_BTN  = 3'd7
  } region_e;

  localparam logic [15:0] DMEM_BASE = 16'h2000;
  localparam logic [15:0] LEDR_BASE = 16'h7000;
  localparam logic [15:0] LEDG_BASE = 16'h7010;
  localparam logic [15:0] HEX_BASE  = 16'h7020;
  localparam logic [15:0] LCD_BASE  = 16'h7030;
  localparam logic [15:0] SW_BASE   = 16'h7800;
  localparam logic [15:0] BTN_BASE  = 16'h7810;

  // Byte enables over two words, so a
  // misaligned access spills into [7:4].
  function automatic logic [7:0] byte_en(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [7:0] b;
    b = 8'h00;
    unique case (1'b1)
      (size == SZ_B): b = 8'h01;
      (size == SZ_H): b = 8'h03;
      (size == SZ_W): b = 8'h0F;
      default:        b = 8'h00;
    endcase
    return b << off;
  endfunction

  function automatic logic [31:0] load_extend(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  off,
    input logic        uns
  );
    logic [31:0] s;
    logic [31:0] r;
    s = word >> {off, 3'b000};
    r = 32'd0;
    unique case (1'b1)
      (size == SZ_B):
        r = uns ? {24'd0, s[7:0]}
                : {{24{s[7]}}, s[7:0]};
      (size == SZ_H):
        r = uns ? {16'd0, s[15:0]}
                : {{16{s[15]}}, s[15:0]};
      (size == SZ_W): r = s;
      default:        r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_sp.sv
// Single-port data RAM: synchronous read,
// per-byte write enables, contents not reset.
module dmem_sp #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // Byte-lane write and registered read
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/lsu_mmio_pipe.sv
// Handshaked LSU: DMEM, output registers and
// synchronised inputs behind a 16-bit map.
module lsu_mmio_pipe
  import lsu_pkg::*;
#(
  parameter int DMEM_AW          = 13,
  parameter int NUM_HEX          = 8,
  parameter int SYNC_STAGES      = 2,
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_wren,
  input  logic [15:0]          i_req_addr,
  input  logic [1:0]           i_req_size,
  input  logic                 i_req_uns,
  input  logic [31:0]          i_req_wdata,
  output logic                 o_rsp_valid,
  output logic [31:0]          o_rsp_rdata,
  output logic                 o_rsp_err,
  input  logic [31:0]          i_io_sw,
  input  logic [3:0]           i_io_btn,
  output logic [31:0]          o_io_ledr,
  output logic [31:0]          o_io_ledg,
  output logic [31:0]          o_io_lcd,
  output logic [7*NUM_HEX-1:0] o_io_hex
);

  localparam int WAW = DMEM_AW - 2;
  localparam logic [16:0] DM_LO =
    {1'b0, DMEM_BASE};
  localparam logic [16:0] DM_HI =
    DM_LO + (17'd1 << DMEM_AW);
  localparam logic SPLIT_EN =
    (SPLIT_MISALIGNED != 0);

  state_e   state;
  logic     accept;
  logic     per_we;
  logic     in_dm;
  region_e  rg;
  logic     mis;
  logic     is_per;
  logic     bad_off;
  logic     split;
  logic     err;
  logic     last_w;
  logic [WAW-1:0] widx;
  logic [7:0]     be8;
  logic [63:0]    sh64;

  logic           q_wren;
  logic [1:0]     q_size;
  logic           q_uns;
  logic [1:0]     q_off;
  logic           q_hi;
  region_e        q_rg;
  logic           q_err;
  logic           q_split;
  logic [WAW-1:0] q_widx;
  logic [3:0]     q_be_hi;
  logic [31:0]    q_wd_hi;
  logic [31:0]    q_lo;

  logic           dm_en;
  logic [3:0]     dm_we;
  logic [WAW-1:0] dm_addr;
  logic [31:0]    dm_wdata;
  logic [31:0]    dm_rdata;

  logic [31:0] sw_sr  [SYNC_STAGES];
  logic [3:0]  btn_sr [SYNC_STAGES];
  logic [6:0]  hex_q  [8];
  logic [31:0] hex_w;
  logic [31:0] per_word;
  logic [31:0] rd_word;
  logic [31:0] merged;

  assign accept =
    i_rst & i_req_valid & o_req_ready;

  assign in_dm =
    ({1'b0, i_req_addr} >= DM_LO) &&
    ({1'b0, i_req_addr} <  DM_HI);

  assign widx =
    WAW'((i_req_addr - DMEM_BASE) >> 2);
  assign last_w = &widx;
  assign be8 =
    byte_en(i_req_size, i_req_addr[1:0]);
  assign sh64 =
    {32'd0, i_req_wdata}
      << {i_req_addr[1:0], 3'b000};

  // Map the request address onto a region
  always_comb begin
    rg = RG_NONE;
    unique case (1'b1)
      in_dm:
        rg = RG_DMEM;
      (i_req_addr[15:4] == LEDR_BASE[15:4]):
        rg = RG_LEDR;
      (i_req_addr[15:4] == LEDG_BASE[15:4]):
        rg = RG_LEDG;
      (i_req_addr[15:4] == HEX_BASE[15:4]):
        rg = RG_HEX;
      (i_req_addr[15:4] == LCD_BASE[15:4]):
        rg = RG_LCD;
      (i_req_addr[15:4] == SW_BASE[15:4]):
        rg = RG_SW;
      (i_req_addr[15:4] == BTN_BASE[15:4]):
        rg = RG_BTN;
      default:
        rg = RG_NONE;
    endcase
  end

  // Every error is decided before a beat
  // is issued, so nothing commits partially.
  always_comb begin
    mis =
      (i_req_size == SZ_H && i_req_addr[0]) ||
      (i_req_size == SZ_W &&
       i_req_addr[1:0] != 2'b00);
    is_per = (rg != RG_NONE) &&
             (rg != RG_DMEM);
    bad_off = (rg == RG_HEX)
      ? i_req_addr[3]
      : (is_per && i_req_addr[3:2] != 2'b00);
    split = SPLIT_EN && (rg == RG_DMEM) && mis;
    err = (i_req_size == SZ_X) ||
          (rg == RG_NONE) ||
          bad_off ||
          (mis && (is_per || !SPLIT_EN)) ||
          (i_req_wren &&
           (rg == RG_SW || rg == RG_BTN)) ||
          (split && last_w);
  end

  assign per_we = accept & i_req_wren & ~err;

  // First beat on accept, second beat from
  // the held request; reset kills beat two.
  always_comb begin
    dm_en    = 1'b0;
    dm_we    = 4'b0000;
    dm_addr  = widx;
    dm_wdata = sh64[31:0];
    if (state == IDLE) begin
      dm_en = accept && rg == RG_DMEM && !err;
      if (dm_en && i_req_wren) begin
        dm_we = be8[3:0];
      end
    end else if (state == ACC && q_split) begin
      dm_en    = i_rst;
      dm_addr  = q_widx + WAW'(1);
      dm_wdata = q_wd_hi;
      if (i_rst && q_wren) begin
        dm_we = q_be_hi;
      end
    end
  end

  dmem_sp #(
    .AW (WAW)
  ) u_dmem (
    .clk   (i_clk),
    .en    (dm_en),
    .we    (dm_we),
    .addr  (dm_addr),
    .wdata (dm_wdata),
    .rdata (dm_rdata)
  );

  // Input synchronisers for switches/buttons
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sr[i]  <= '0;
        btn_sr[i] <= '0;
      end
    end else begin
      sw_sr[0]  <= i_io_sw;
      btn_sr[0] <= i_io_btn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sr[i]  <= sw_sr[i-1];
        btn_sr[i] <= btn_sr[i-1];
      end
    end
  end

  // Word-wide output registers, byte writes
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_io_ledr <= '0;
      o_io_ledg <= '0;
      o_io_lcd  <= '0;
    end else if (per_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be8[b]) begin
          if (rg == RG_LEDR)
            o_io_ledr[8*b +: 8] <= sh64[8*b +: 8];
          if (rg == RG_LEDG)
            o_io_ledg[8*b +: 8] <= sh64[8*b +: 8];
          if (rg == RG_LCD)
            o_io_lcd[8*b +: 8] <= sh64[8*b +: 8];
        end
      end
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_hex
    if (k < NUM_HEX) begin : g_on
      logic [6:0] r;
      // One digit; byte lane k%4 of word k/4
      always_ff @(posedge i_clk) begin
        if (!i_rst) begin
          r <= '0;
        end else if (per_we && rg == RG_HEX &&
                     i_req_addr[2] == 1'(k / 4) &&
                     be8[k % 4]) begin
          r <= sh64[8*(k % 4) +: 7];
        end
      end
      assign hex_q[k] = r;
      assign o_io_hex[7*k +: 7] = r;
    end else begin : g_off
      assign hex_q[k] = 7'd0;
    end
  end

  // Readback word for the held peripheral
  always_comb begin
    hex_w = '0;
    for (int b = 0; b < 4; b++) begin
      hex_w[8*b +: 8] = q_hi
        ? {1'b0, hex_q[4 + b]}
        : {1'b0, hex_q[b]};
    end
    per_word = '0;
    unique case (q_rg)
      RG_LEDR: per_word = o_io_ledr;
      RG_LEDG: per_word = o_io_ledg;
      RG_LCD:  per_word = o_io_lcd;
      RG_HEX:  per_word = hex_w;
      RG_SW:   per_word = sw_sr[SYNC_STAGES-1];
      RG_BTN:
        per_word = {28'd0, btn_sr[SYNC_STAGES-1]};
      default: per_word = '0;
    endcase
  end

  assign rd_word =
    (q_rg == RG_DMEM) ? dm_rdata : per_word;
  assign merged =
    32'({dm_rdata, q_lo} >> {q_off, 3'b000});

  // Control FSM with registered handshake
  // and response outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state       <= IDLE;
      o_req_ready <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
      q_wren      <= 1'b0;
      q_size      <= '0;
      q_uns       <= 1'b0;
      q_off       <= '0;
      q_hi        <= 1'b0;
      q_rg        <= RG_NONE;
      q_err       <= 1'b0;
      q_split     <= 1'b0;
      q_widx      <= '0;
      q_be_hi     <= '0;
      q_wd_hi     <= '0;
      q_lo        <= '0;
    end else begin
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          o_req_ready <= 1'b1;
          if (accept) begin
            o_req_ready <= 1'b0;
            state       <= ACC;
            q_wren      <= i_req_wren;
            q_size      <= i_req_size;
            q_uns       <= i_req_uns;
            q_off       <= i_req_addr[1:0];
            q_hi        <= i_req_addr[2];
            q_rg        <= rg;
            q_err       <= err;
            q_split     <= split & ~err;
            q_widx      <= widx;
            q_be_hi     <= be8[7:4];
            q_wd_hi     <= sh64[63:32];
          end
        end
        ACC: begin
          if (q_split) begin
            q_lo  <= dm_rdata;
            state <= ACC2;
          end else begin
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= q_err;
            if (!q_err && !q_wren) begin
              o_rsp_rdata <= load_extend(
                rd_word, q_size, q_off, q_uns);
            end
            o_req_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        ACC2: begin
          o_rsp_valid <= 1'b1;
          if (!q_wren) begin
            o_rsp_rdata <= load_extend(
              merged, q_size, 2'b00, q_uns);
          end
          o_req_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          o_req_ready <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mmio_pipe.sv
// Directed bench for lsu_mmio_pipe: vector
// table plus reset, sync and abort sequences.
module tb_lsu_mmio_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wren;
  logic [15:0] req_addr;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] io_sw;
  logic [3:0]  io_btn;
  logic [31:0] io_ledr;
  logic [31:0] io_ledg;
  logic [31:0] io_lcd;
  logic [55:0] io_hex;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_mmio_pipe dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_wren  (req_wren),
    .i_req_addr  (req_addr),
    .i_req_size  (req_size),
    .i_req_uns   (req_uns),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err),
    .i_io_sw     (io_sw),
    .i_io_btn    (io_btn),
    .o_io_ledr   (io_ledr),
    .o_io_ledg   (io_ledg),
    .o_io_lcd    (io_lcd),
    .o_io_hex    (io_hex)
  );

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ee;
    int          lat;
  } vec_t;

  localparam int NV = 30;
  vec_t vt [NV];

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h",
               nm, act, exp);
    end
  endtask

  // Called away from a clock edge; holds the
  // request until accepted, then waits for rsp.
  task automatic xact(
    input  logic        w,
    input  logic [15:0] a,
    input  logic [1:0]  sz,
    input  logic        u,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ee,
    output int          lat
  );
    int n;
    req_valid = 1'b1;
    req_wren  = w;
    req_addr  = a;
    req_size  = sz;
    req_uns   = u;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1;
    rd  = '0;
    ee  = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        lat = c;
        rd  = rsp_rdata;
        ee  = rsp_err;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        ee;
    int          lat;
    logic [55:0] exph;
    logic        seen;

    vt[0]  = '{0, 16'h7000, 2, 0, 32'h0,
               32'h0, 0, 1};
    vt[1]  = '{1, 16'h2004, 2, 0, 32'hDEADBEEF,
               32'h0, 0, 1};
    vt[2]  = '{0, 16'h2005, 0, 0, 32'h0,
               32'hFFFFFFBE, 0, 1};
    vt[3]  = '{0, 16'h2005, 0, 1, 32'h0,
               32'h000000BE, 0, 1};
    vt[4]  = '{1, 16'h2006, 2, 0, 32'h11223344,
               32'h0, 0, 2};
    vt[5]  = '{0, 16'h2006, 2, 0, 32'h0,
               32'h11223344, 0, 2};
    vt[6]  = '{0, 16'h2008, 1, 0, 32'h0,
               32'h00001122, 0, 1};
    vt[7]  = '{0, 16'h2004, 2, 1, 32'h0,
               32'h3344BEEF, 0, 1};
    vt[8]  = '{0, 16'h2004, 1, 0, 32'h0,
               32'hFFFFBEEF, 0, 1};
    vt[9]  = '{0, 16'h3FFE, 2, 0, 32'h0,
               32'h0, 1, 1};
    vt[10] = '{1, 16'h7800, 2, 0, 32'h12345678,
               32'h0, 1, 1};
    vt[11] = '{1, 16'h7021, 1, 0, 32'hABCD,
               32'h0, 1, 1};
    vt[12] = '{1, 16'h7025, 1, 0, 32'hABCD,
               32'h0, 1, 1};
    vt[13] = '{0, 16'h5000, 2, 0, 32'h0,
               32'h0, 1, 1};
    vt[14] = '{0, 16'h2004, 3, 0, 32'h0,
               32'h0, 1, 1};
    vt[15] = '{1, 16'h7027, 0, 0, 32'hFF,
               32'h0, 0, 1};
    vt[16] = '{0, 16'h7024, 2, 0, 32'h0,
               32'h7F000000, 0, 1};
    vt[17] = '{1, 16'h7020, 2, 0, 32'h01020304,
               32'h0, 0, 1};
    vt[18] = '{0, 16'h7022, 1, 1, 32'h0,
               32'h00000102, 0, 1};
    vt[19] = '{0, 16'h7028, 2, 0, 32'h0,
               32'h0, 1, 1};
    vt[20] = '{1, 16'h7010, 2, 0, 32'h80000001,
               32'h0, 0, 1};
    vt[21] = '{0, 16'h7013, 0, 0, 32'h0,
               32'hFFFFFF80, 0, 1};
    vt[22] = '{0, 16'h7004, 2, 0, 32'h0,
               32'h0, 1, 1};
    vt[23] = '{1, 16'h3FFE, 1, 0, 32'hCAFE,
               32'h0, 0, 1};
    vt[24] = '{0, 16'h3FFE, 1, 1, 32'h0,
               32'h0000CAFE, 0, 1};
    vt[25] = '{1, 16'h3FFE, 2, 0, 32'h99999999,
               32'h0, 1, 1};
    vt[26] = '{0, 16'h3FFE, 1, 1, 32'h0,
               32'h0000CAFE, 0, 1};
    vt[27] = '{0, 16'h2006, 2, 0, 32'h0,
               32'h11223344, 0, 2};
    vt[28] = '{1, 16'h7032, 1, 0, 32'h5A5A,
               32'h0, 0, 1};
    vt[29] = '{0, 16'h7030, 2, 0, 32'h0,
               32'h5A5A0000, 0, 1};

    rst       = 1'b0;
    req_valid = 1'b0;
    req_wren  = 1'b0;
    req_addr  = '0;
    req_size  = '0;
    req_uns   = 1'b0;
    req_wdata = '0;
    io_sw     = '0;
    io_btn    = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rvalid", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    chk("rst_ledr", 64'(io_ledr), 64'd0);
    chk("rst_ledg", 64'(io_ledg), 64'd0);
    chk("rst_lcd", 64'(io_lcd), 64'd0);
    chk("rst_hex", 64'(io_hex), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < NV; i++) begin
      xact(vt[i].w, vt[i].a, vt[i].sz,
           vt[i].u, vt[i].wd, rd, ee, lat);
      chk($sformatf("v%0d_lat", i),
          64'(lat), 64'(vt[i].lat));
      chk($sformatf("v%0d_rdata", i),
          64'(rd), 64'(vt[i].rd));
      chk($sformatf("v%0d_err", i),
          64'(ee), 64'(vt[i].ee));
      @(posedge clk); #1;
      chk($sformatf("v%0d_strobe", i),
          64'(rsp_valid), 64'd0);
    end

    exph = {7'h7F, 7'h00, 7'h00, 7'h00,
            7'h01, 7'h02, 7'h03, 7'h04};
    chk("hex_all", 64'(io_hex), 64'(exph));
    chk("hex_d7", 64'(io_hex[55:49]), 64'h7F);
    chk("ledr", 64'(io_ledr), 64'd0);
    chk("ledg", 64'(io_ledg), 64'h80000001);
    chk("lcd", 64'(io_lcd), 64'h5A5A0000);

    xact(0, 16'h7800, 2, 0, 0, rd, ee, lat);
    chk("sw_init", 64'(rd), 64'd0);
    io_sw  = 32'hA5A5A5A5;
    io_btn = 4'hA;
    xact(0, 16'h7800, 2, 0, 0, rd, ee, lat);
    chk("sw_early", 64'(rd), 64'd0);
    xact(0, 16'h7800, 2, 0, 0, rd, ee, lat);
    chk("sw_late", 64'(rd), 64'hA5A5A5A5);
    xact(0, 16'h7810, 2, 0, 0, rd, ee, lat);
    chk("btn", 64'(rd), 64'hA);
    xact(0, 16'h7810, 0, 0, 0, rd, ee, lat);
    chk("btn_byte", 64'(rd), 64'h0A);

    xact(1, 16'h2010, 2, 0, 0, rd, ee, lat);
    xact(1, 16'h2014, 2, 0, 0, rd, ee, lat);
    req_valid = 1'b1;
    req_wren  = 1'b1;
    req_addr  = 16'h2012;
    req_size  = 2'd2;
    req_uns   = 1'b0;
    req_wdata = 32'hAABBCCDD;
    chk("abort_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_rvalid", 64'(rsp_valid), 64'd0);
    chk("abort_ready_lo", 64'(req_ready), 64'd0);
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("abort_no_rsp", 64'(seen), 64'd0);
    chk("abort_idle", 64'(req_ready), 64'd1);
    xact(0, 16'h2010, 2, 0, 0, rd, ee, lat);
    chk("abort_beat1", 64'(rd), 64'hCCDD0000);
    xact(0, 16'h2014, 2, 0, 0, rd, ee, lat);
    chk("abort_beat2", 64'(rd), 64'h00000000);
    chk("abort_hex", 64'(io_hex), 64'd0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mmio_pipe.md
Name: lsu_mmio_pipe

Overview:
Handshaked, parametrised load-store unit for the RV32I core, replacing the single-cycle LSU. It decodes a 16-bit address into a synchronous-read DMEM, output peripheral registers (LEDR/LEDG/HEX/LCD) and synchronised inputs (switches/buttons). It adds valid/ready request handshaking, a registered response, two-beat splitting of misaligned DMEM accesses, and an access-error flag.

Parameters:
DMEM_AW, 13, DMEM byte-address width; DMEM base 0x2000, size 2^DMEM_AW bytes
NUM_HEX, 8, number of 7-segment digits (1..8)
SYNC_STAGES, 2, flip-flop stages on i_io_sw/i_io_btn (>=2)
SPLIT_MISALIGNED, 1, 1 = misaligned DMEM access split into two beats; 0 = flagged as error

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-low
i_req_valid  in  1  request valid
o_req_ready  out  1  request accepted when valid&ready
i_req_wren  in  1  1 = store, 0 = load
i_req_addr  in  16  byte address
i_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
i_req_uns  in  1  zero-extend loads
i_req_wdata  in  32  store data, LSB-aligned
o_rsp_valid  out  1  one-cycle response strobe
o_rsp_rdata  out  32  load data, extended; 0 for stores and errors
o_rsp_err  out  1  access error, valid with o_rsp_valid
i_io_sw  in  32  switches
i_io_btn  in  4  buttons
o_io_ledr, o_io_ledg, o_io_lcd  out  32 each  output registers
o_io_hex  out  7*NUM_HEX  digit k = bits [7k+6:7k]

Behaviour:
- Memory map: DMEM at 0x2000..0x2000+2^DMEM_AW-1; LEDR 0x7000-0x700F; LEDG 0x7010-0x701F; HEX 0x7020-0x7027, one byte per digit, low 7 bits used, digits >= NUM_HEX read 0 and ignore writes; LCD 0x7030-0x703F; SW 0x7800-0x780F (RO); BTN 0x7810-0x781F (RO, zero-extended). Any other address is an error.
- Peripheral windows alias on addr[3:0]; the word is selected by addr[3:2]==0, and all other offsets are errors.
- Reset (i_rst==0 at the edge): state IDLE; o_req_ready=0 during reset, then 1; o_rsp_valid=0; o_rsp_rdata=0; o_rsp_err=0; all output registers 0; sync chains 0. DMEM contents are not reset.
- Reset asserted mid-operation aborts the access. No response is produced, a pending second store beat is dropped, and the first beat remains committed.
- FSM: IDLE -> (accept) ACC -> IDLE; or IDLE -> ACC -> ACC2 -> IDLE for a split access.
- o_req_ready=1 only in IDLE. Maximum throughput is one request per 2 cycles.
- Latency: accept at edge T; o_rsp_valid high for exactly the cycle after edge T+1 (aligned or error). A split access responds one cycle later.
- Stores commit at edge T (aligned) or at edges T and T+1 (split). Byte-enables come from size and addr[1:0]; data is shifted into the lane.
- Loads select the lane, then sign- or zero-extend per i_req_uns. A word load ignores i_req_uns.
- Misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
- Misaligned in DMEM with SPLIT_MISALIGNED=1: beat 1 uses the word at addr&~3, beat 2 uses the next word, and data is merged little-endian.
- Misaligned with SPLIT_MISALIGNED=0, misaligned to any peripheral, size==3, a store to SW/BTN, or a split whose second word lies past the DMEM end: error. No state changes, rdata=0.
- Error checking happens before any beat is issued, so there are no partial writes.
- A load of an output register returns its current value; HEX bytes are zero-padded to 8 bits.
- SW/BTN loads return the synchronised value, SYNC_STAGES cycles behind the pins.
- A request presented while o_req_ready=0 is ignored. The requester holds valid and the fields stable until accepted.

Decomposition:
- Package lsu_pkg holds:
  - enum size_e;
  - enum state_e {IDLE, ACC, ACC2};
  - region enum;
  - address constants DMEM_BASE, LEDR_BASE, LEDG_BASE, HEX_BASE, LCD_BASE, SW_BASE, BTN_BASE;
  - function byte_en(size, off) and function load_extend(word, size, off, uns).
- Sub-module dmem_sp: single-port, synchronous-read, byte-enable RAM of 2^(DMEM_AW-2) words.

Test Plan:
- Reset low for 3 cycles then high -> all outputs 0 and ready=1 on the first cycle after reset release; a LEDR load returns 0x00000000.
- Word store 0xDEADBEEF @0x2004, then byte load @0x2005 signed -> rsp rdata 0xFFFFFFBE, err=0, rsp 1 cycle after accept edge; unsigned -> 0x000000BE.
- Split: word store 0x11223344 @0x2006, then word load @0x2006 -> 0x11223344 two cycles after accept; half load @0x2008 -> 0x00001122.
- Errors, each giving err=1, rdata=0, DMEM/regs unchanged:
  - word load @0x3FFE (DMEM end);
  - store @0x7800;
  - half store @0x7021;
  - load @0x5000.
- HEX byte store 0xFF @0x7027 -> o_io_hex[55:49]=0x7F and other digits unchanged; load @0x7024 word -> upper byte 0x7F.
- i_io_sw=0xA5A5A5A5 set at cycle N -> a load @0x7800 returns the old value before N+SYNC_STAGES and 0xA5A5A5A5 after; reset asserted between split beats -> no rsp, FSM in IDLE.
